// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared receive-path types and constants for the USART receiver.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int SAMPLES_PER_BIT = 16;
  localparam int SAMPLE_MID      = 8;
  localparam int BRGL_MULT       = 4;
  localparam int RX_ENTRY_W      = 9;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +----------------------------------------------------------------------+
// | uart_rx_fifo                                                         |
// | Depth-parameterised circular FIFO; head entry is always presented.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_W'(DEPTH));
  assign w_pop  = pop && !empty && !flush;
  // A pop frees the slot before the push lands, so full+pop+push is legal.
  assign w_push = push && (!full || w_pop) && !flush;
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_engine.sv
// +----------------------------------------------------------------------+
// | uart_rx_engine                                                       |
// | 16x oversampled asynchronous receiver with RCREG FIFO and status.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RXD,
  input  logic       spen,
  input  logic       cren,
  input  logic       brgh,
  input  logic [7:0] spbrg,
  input  logic       rcreg_rd_en,
  output logic [7:0] rcreg_out,
  output logic       ferr,
  output logic       oerr,
  output logic       rxif_set_en,
  output logic       rx_busy
);

  localparam logic [3:0] c_idx_first_smp = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] c_idx_mid_smp   = 4'(SAMPLE_MID);
  localparam logic [3:0] c_idx_last_smp  = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] c_idx_end       = 4'(SAMPLES_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  rx_state_e              r_state;
  rx_state_e              w_state_nxt;
  logic [9:0]             r_presc;
  logic [9:0]             w_presc_max;
  logic [3:0]             r_idx;
  logic                   r_s7;
  logic                   r_s8;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitcnt;
  logic                   r_oerr;
  logic                   w_rx_sync;
  logic                   w_tick;
  logic                   w_maj;
  logic                   w_active;
  logic                   w_fall;
  logic                   w_start;
  logic                   w_push;
  logic                   w_full;
  logic                   w_empty;
  logic [RX_ENTRY_W-1:0]  w_head;

  generate
    if (SYNC_STAGES > 1) begin : g_sync_multi
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '1;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], UART_RXD};
      end
    end else begin : g_sync_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '1;
        else      r_sync <= UART_RXD;
      end
    end
  endgenerate

  assign w_rx_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_prev <= 1'b1;
    else      r_rx_prev <= w_rx_sync;
  end

  // One tick every (spbrg+1) clocks with brgh, BRGL_MULT times slower without.
  assign w_presc_max = brgh ? 10'(spbrg) : 10'(BRGL_MULT * (int'(spbrg) + 1) - 1);
  assign w_tick      = (r_presc == w_presc_max);
  assign w_maj       = majority3(r_s7, r_s8, w_rx_sync);
  assign w_active    = spen && cren && !r_oerr;
  assign w_fall      = r_rx_prev && !w_rx_sync;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_push      = 1'b0;
    if (!spen || !cren) begin
      w_state_nxt = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (w_active && w_fall) begin
            w_state_nxt = RX_START;
            w_start     = 1'b1;
          end
        end
        RX_START: begin
          if (w_tick && (r_idx == c_idx_last_smp) && w_maj) w_state_nxt = RX_IDLE;
          else if (w_tick && (r_idx == c_idx_end))          w_state_nxt = RX_DATA;
        end
        RX_DATA: begin
          if (w_tick && (r_idx == c_idx_end) && (r_bitcnt == 3'd7)) w_state_nxt = RX_STOP;
        end
        RX_STOP: begin
          if (w_tick && (r_idx == c_idx_last_smp)) begin
            w_push      = 1'b1;
            w_state_nxt = RX_IDLE;
          end
        end
        default: w_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RX_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_s7     <= 1'b0;
      r_s8     <= 1'b0;
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_start) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_bitcnt <= '0;
    end else if (r_state != RX_IDLE) begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 4'd1;
        if (r_idx == c_idx_first_smp) r_s7 <= w_rx_sync;
        if (r_idx == c_idx_mid_smp)   r_s8 <= w_rx_sync;
        if ((r_state == RX_DATA) && (r_idx == c_idx_last_smp)) r_shift  <= {w_maj, r_shift[7:1]};
        if ((r_state == RX_DATA) && (r_idx == c_idx_end))      r_bitcnt <= r_bitcnt + 3'd1;
      end else begin
        r_presc <= r_presc + 10'd1;
      end
    end
  end

  // Overrun only when the push finds no room; a same-cycle read makes room.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_oerr <= 1'b0;
    else if (!spen || !cren)                      r_oerr <= 1'b0;
    else if (w_push && w_full && !rcreg_rd_en)    r_oerr <= 1'b1;
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RX_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!spen),
    .push  (w_push),
    .pop   (rcreg_rd_en),
    .din   ({~w_maj, r_shift}),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign rcreg_out   = w_empty ? 8'h00 : w_head[7:0];
  assign ferr        = w_empty ? 1'b0  : w_head[8];
  assign oerr        = r_oerr;
  assign rxif_set_en = !w_empty;
  assign rx_busy     = (r_state != RX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
// +----------------------------------------------------------------------+
// | tb_uart_rx_engine                                                    |
// | Scoreboard bench: expected bytes queued at send, compared at read.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       UART_RXD = 1'b1;
  logic       spen = 1'b0;
  logic       cren = 1'b0;
  logic       brgh = 1'b1;
  logic [7:0] spbrg = 8'd0;
  logic       rcreg_rd_en = 1'b0;
  logic [7:0] rcreg_out;
  logic       ferr;
  logic       oerr;
  logic       rxif_set_en;
  logic       rx_busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_engine #(
    .FIFO_DEPTH  (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .UART_RXD    (UART_RXD),
    .spen        (spen),
    .cren        (cren),
    .brgh        (brgh),
    .spbrg       (spbrg),
    .rcreg_rd_en (rcreg_rd_en),
    .rcreg_out   (rcreg_out),
    .ferr        (ferr),
    .oerr        (oerr),
    .rxif_set_en (rxif_set_en),
    .rx_busy     (rx_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start, 8 data bits LSB first, stop, then one idle bit time.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int cpb);
    UART_RXD = 1'b0;
    wait_clk(cpb);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = d[i];
      wait_clk(cpb);
    end
    UART_RXD = stop_bit;
    wait_clk(cpb);
    UART_RXD = 1'b1;
    wait_clk(cpb);
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] e;
    check({tag, ":sb_empty"}, 32'(sb.size() == 0), 32'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ":rxif"}, 32'(rxif_set_en), 32'd1);
      check({tag, ":data"}, 32'(rcreg_out), 32'(e[7:0]));
      check({tag, ":ferr"}, 32'(ferr), 32'(e[8]));
    end
    rcreg_rd_en = 1'b1;
    wait_clk(1);
    rcreg_rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    wait_clk(3);
    check("rst:rcreg", 32'(rcreg_out), 32'd0);
    check("rst:ferr", 32'(ferr), 32'd0);
    check("rst:oerr", 32'(oerr), 32'd0);
    check("rst:rxif", 32'(rxif_set_en), 32'd0);
    check("rst:busy", 32'(rx_busy), 32'd0);
    rst  = 1'b1;
    spen = 1'b1;
    cren = 1'b1;
    wait_clk(4);

    // Basic frame with latency measured in clock edges after the pin edge.
    sb.push_back({1'b0, 8'hCA});
    cnt = 0;
    fork
      send_frame(8'hCA, 1'b1, 16);
      begin
        for (cnt = 0; cnt < 400; cnt++) begin
          wait_clk(1);
          if (rxif_set_en) break;
        end
      end
    join
    check("basic:latency", 32'(cnt), 32'd156);
    pop_check("basic");
    check("basic:rxif_after_rd", 32'(rxif_set_en), 32'd0);
    check("basic:rcreg_after_rd", 32'(rcreg_out), 32'd0);
    rcreg_rd_en = 1'b1;
    wait_clk(1);
    rcreg_rd_en = 1'b0;
    check("empty_pop:rxif", 32'(rxif_set_en), 32'd0);

    // Glitch: short low pulse enters START then aborts.
    UART_RXD = 1'b0;
    wait_clk(4);
    UART_RXD = 1'b1;
    wait_clk(2);
    check("glitch:busy", 32'(rx_busy), 32'd1);
    wait_clk(40);
    check("glitch:idle", 32'(rx_busy), 32'd0);
    check("glitch:rxif", 32'(rxif_set_en), 32'd0);

    // Framing error at 128 clk per bit.
    spbrg = 8'd1;
    brgh  = 1'b0;
    wait_clk(2);
    sb.push_back({1'b1, 8'h55});
    send_frame(8'h55, 1'b0, 128);
    check("ferr:rxif", 32'(rxif_set_en), 32'd1);
    pop_check("ferr");
    spbrg = 8'd0;
    brgh  = 1'b1;
    wait_clk(2);

    // Overrun.
    sb.push_back({1'b0, 8'h11});
    sb.push_back({1'b0, 8'h22});
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    check("ovr:oerr_before", 32'(oerr), 32'd0);
    send_frame(8'h33, 1'b1, 16);
    check("ovr:oerr", 32'(oerr), 32'd1);
    send_frame(8'h99, 1'b1, 16);
    check("ovr:blocked_busy", 32'(rx_busy), 32'd0);
    pop_check("ovr0");
    pop_check("ovr1");
    check("ovr:rxif_drained", 32'(rxif_set_en), 32'd0);
    check("ovr:oerr_sticky", 32'(oerr), 32'd1);
    cren = 1'b0;
    wait_clk(1);
    check("ovr:oerr_cleared", 32'(oerr), 32'd0);
    cren = 1'b1;
    wait_clk(2);
    sb.push_back({1'b0, 8'h44});
    send_frame(8'h44, 1'b1, 16);
    pop_check("ovr_recover");

    // Read coincides with the push into a full FIFO.
    sb.push_back({1'b0, 8'hA1});
    sb.push_back({1'b0, 8'hA2});
    sb.push_back({1'b0, 8'hA3});
    send_frame(8'hA1, 1'b1, 16);
    send_frame(8'hA2, 1'b1, 16);
    fork
      send_frame(8'hA3, 1'b1, 16);
      begin
        wait_clk(156);
        pop_check("simul_pop");
      end
    join
    check("simul:oerr", 32'(oerr), 32'd0);
    pop_check("simul1");
    pop_check("simul2");
    check("simul:rxif", 32'(rxif_set_en), 32'd0);

    // spen low flushes the FIFO.
    send_frame(8'h5A, 1'b1, 16);
    check("spen:rxif_before", 32'(rxif_set_en), 32'd1);
    spen = 1'b0;
    wait_clk(1);
    check("spen:rxif", 32'(rxif_set_en), 32'd0);
    check("spen:rcreg", 32'(rcreg_out), 32'd0);
    spen = 1'b1;
    wait_clk(2);

    // Reset during DATA bit 3 with an unread byte held in the FIFO.
    send_frame(8'hF0, 1'b1, 16);
    fork
      send_frame(8'h3C, 1'b1, 16);
      begin
        wait_clk(16 * 4 + 8);
        check("mrst:busy_before", 32'(rx_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mrst:busy", 32'(rx_busy), 32'd0);
        check("mrst:rxif", 32'(rxif_set_en), 32'd0);
        check("mrst:rcreg", 32'(rcreg_out), 32'd0);
        check("mrst:ferr", 32'(ferr), 32'd0);
        check("mrst:oerr", 32'(oerr), 32'd0);
      end
    join
    sb.delete();
    rst = 1'b1;
    wait_clk(4);
    sb.push_back({1'b0, 8'h7E});
    send_frame(8'h7E, 1'b1, 16);
    pop_check("mrst_after");
    check("final:rxif", 32'(rxif_set_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Asynchronous receive path of the PIC16F-style USART; consumes the serial stream on UART_RXD, the same frame format the transmit shift register drives on UART_TXD.
- Oversamples at 16x using the SPBRG/BRGH baud rule and majority-votes each bit.
- Pushes assembled bytes into a 2-deep RCREG FIFO and drives the RCIF/FERR/OERR status consumed by the uart wrapper.

Parameters:
- FIFO_DEPTH, 2, number of received-byte entries; RCREG is the head entry.
- SYNC_STAGES, 2, flops in the RXD input synchroniser.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- UART_RXD  in  1  serial input, idle high
- spen  in  1  serial port enable (RCSTA<7>)
- cren  in  1  continuous receive enable (RCSTA<4>)
- brgh  in  1  high baud select (TXSTA<2>)
- spbrg  in  8  baud rate divisor
- rcreg_rd_en  in  1  read strobe; pops the head entry
- rcreg_out  out  8  head entry data; 0 when empty
- ferr  out  1  framing error of the head entry
- oerr  out  1  sticky overrun error
- rxif_set_en  out  1  high while the FIFO is non-empty
- rx_busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=0, async):
  - state IDLE, FIFO empty, oerr=0, all outputs 0.
  - Synchroniser flops reset to 1.
- Sample tick:
  - Prescaler counts clk cycles and issues one tick every (spbrg+1) cycles when brgh=1, every 4*(spbrg+1) when brgh=0.
  - This gives 16 ticks per bit; spbrg=0, brgh=1 gives 16 clk/bit.
  - Prescaler and sample index (4-bit, 0..15) are cleared on the IDLE->START transition.
  - The first START cycle is tick index 0.
- Enable:
  - Reception is active only when spen=1 and cren=1 and oerr=0.
- State machine:
  - IDLE: when active and rx_sync goes 1->0 (edge on the synchronised signal), go to START.
  - START:
    - Sample indices 7, 8 and 9 are captured; majority is taken at index 9.
    - Majority=1 is a false start: return to IDLE, nothing pushed.
    - At index 15 go to DATA with bit counter=0.
  - DATA:
    - Majority of indices 7/8/9 is shifted in LSB first.
    - At index 15 increment the bit counter; after bit 7 go to STOP.
  - STOP:
    - Majority at index 9: 1 means ferr_bit=0, 0 means ferr_bit=1.
    - On the next cycle push {ferr_bit, data} and return to IDLE. The push happens even with a framing error.
- FIFO:
  - Head entry drives rcreg_out and ferr.
  - rxif_set_en = not empty. It is a level, and remains high while entries remain.
  - Pop on rcreg_rd_en when non-empty; a pop on empty is ignored.
  - Push when full: data discarded, oerr set. oerr is sticky and blocks new start detection.
  - Simultaneous push and pop when full: pop then push, no overrun.
  - Simultaneous push and pop when empty: push only.
- cren 1->0:
  - Abort any frame, go to IDLE, clear oerr.
  - FIFO contents are retained.
- spen=0:
  - Abort, go to IDLE, flush FIFO, clear oerr.
- Line held low in IDLE (break): no new start until rx_sync returns to 1 and falls again.

Decomposition:
- Package uart_pkg holds:
  - rx state enum {RX_IDLE, RX_START, RX_DATA, RX_STOP}.
  - Constants SAMPLES_PER_BIT=16, SAMPLE_MID=8, BRGL_MULT=4.
- Sub-module uart_rx_fifo:
  - Generic depth-parameterised FIFO of 9-bit entries.
  - Ports: push, pop, full, empty, head.
- Prescaler, synchroniser and FSM stay in uart_rx_engine.

Test Plan:
- Basic frame:
  - Stimulus: spbrg=0, brgh=1, spen=cren=1; drive frame 0xCA at 16 clk/bit.
  - Response: rxif_set_en rises 156 clk after the pin falling edge; rcreg_out=0xCA, ferr=0.
  - Then pulse rcreg_rd_en: rxif_set_en=0, rcreg_out=0.
- Glitch rejection:
  - Stimulus: 4-clk low pulse on idle line.
  - Response: START entered, returns to IDLE at index 9; no push, rxif_set_en stays 0.
- Framing error and slow baud:
  - Stimulus: frame 0x55 with stop bit driven 0, spbrg=1, brgh=0 (128 clk/bit).
  - Response: rcreg_out=0x55, ferr=1, rxif_set_en=1.
- Overrun:
  - Stimulus: send 0x11, 0x22, 0x33 without reads.
  - Response: FIFO holds 0x11, 0x22; oerr=1; a 4th frame is ignored.
  - Pops return 0x11 then 0x22.
  - cren pulse 0 clears oerr; the next frame 0x44 is received.
- Simultaneous push and pop:
  - Stimulus: FIFO full (0xA1, 0xA2); rcreg_rd_en coincides with the push of 0xA3.
  - Response: oerr=0; reads give 0xA2 then 0xA3.
- Mid-frame reset:
  - Stimulus: assert rst=0 during DATA bit 3.
  - Response: immediately state IDLE, outputs 0, rx_busy=0.
  - After release, a full frame 0x7E is received correctly.
